// File: rtl/cp0_unit.sv
// cp0_unit -- MIPS-style coprocessor 0 register block.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. It handles mtc0 writes,
// combinational mfc0 reads, exception entry and eret, the Count/Compare timer
// interrupt, and external interrupt sampling.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   write_en/addr/data            mtc0 write, address {rd,sel}
//   read_addr, read_data          mfc0 read, address {rd,sel}
//   exc_valid/code/epc/bd         exception commit
//   exc_badvaddr_en/badvaddr      faulting address capture
//   eret                          exception return commit
//   hw_int                        level-sensitive external interrupt lines
//   status, cause, epc            current register values
//   int_pending, timer_int        interrupt request outputs
module cp0_unit #(
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [7:0]            write_addr,
  input  logic [31:0]           write_data,
  input  logic [7:0]            read_addr,
  output logic [31:0]           read_data,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_epc,
  input  logic                  exc_bd,
  input  logic                  exc_badvaddr_en,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc,
  output logic                  int_pending,
  output logic                  timer_int
);

  localparam int TICK_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(COUNT_DIV - 1);

  localparam logic [7:0] ADDR_BADVADDR = 8'd64;
  localparam logic [7:0] ADDR_COUNT    = 8'd72;
  localparam logic [7:0] ADDR_COMPARE  = 8'd88;
  localparam logic [7:0] ADDR_STATUS   = 8'd96;
  localparam logic [7:0] ADDR_CAUSE    = 8'd104;
  localparam logic [7:0] ADDR_EPC      = 8'd112;

  logic [31:0]           badvaddr_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic [31:0]           epc_q;
  logic [TICK_W-1:0]     tick_q;
  logic [7:0]            status_im;
  logic                  status_exl;
  logic                  status_ie;
  logic                  cause_bd;
  logic                  cause_ti;
  logic [HW_INT_NUM-1:0] cause_hw;
  logic [1:0]            cause_sw;
  logic [4:0]            cause_exc;

  logic wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [5:0] hw_ip;
  logic [5:0] ip_hi;

  assign wr_badvaddr = write_en && (write_addr == ADDR_BADVADDR);
  assign wr_count    = write_en && (write_addr == ADDR_COUNT);
  assign wr_compare  = write_en && (write_addr == ADDR_COMPARE);
  assign wr_status   = write_en && (write_addr == ADDR_STATUS);
  assign wr_cause    = write_en && (write_addr == ADDR_CAUSE);
  assign wr_epc      = write_en && (write_addr == ADDR_EPC);

  // Unused hardware IP lines read as zero; IP7 also carries the timer interrupt.
  assign hw_ip = 6'(cause_hw);
  assign ip_hi = {hw_ip[5] | cause_ti, hw_ip[4:0]};

  assign status = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause  = {cause_bd, cause_ti, 14'b0, ip_hi, cause_sw, 1'b0, cause_exc, 2'b0};
  assign epc    = epc_q;

  assign timer_int   = cause_ti;
  assign int_pending = status_ie & ~status_exl & (|(cause[15:8] & status_im));

  always_comb begin
    read_data = 32'h0;
    case (read_addr)
      ADDR_BADVADDR: read_data = badvaddr_q;
      ADDR_COUNT:    read_data = count_q;
      ADDR_COMPARE:  read_data = compare_q;
      ADDR_STATUS:   read_data = status;
      ADDR_CAUSE:    read_data = cause;
      ADDR_EPC:      read_data = epc_q;
      default:       read_data = 32'h0;
    endcase
  end

  // Register update. Exception commit owns EPC, Cause, Status and (when
  // capturing) BadVAddr; eret owns Status. A same-cycle mtc0 to an owned
  // register is dropped. Count/Compare are never owned by exception events.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      epc_q      <= 32'h0;
      tick_q     <= '0;
      status_im  <= 8'h0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ti   <= 1'b0;
      cause_hw   <= '0;
      cause_sw   <= 2'b0;
      cause_exc  <= 5'b0;
    end else begin
      cause_hw <= hw_int;

      // A Count write restarts the prescaler and suppresses that cycle's increment.
      if (wr_count) begin
        count_q <= write_data;
        tick_q  <= '0;
      end else if (tick_q == TICK_MAX) begin
        count_q <= count_q + 32'd1;
        tick_q  <= '0;
      end else begin
        tick_q  <= tick_q + 1'b1;
      end

      // Compare write acknowledges the timer and beats a same-cycle match.
      if (wr_compare) begin
        compare_q <= write_data;
        cause_ti  <= 1'b0;
      end else if (count_q == compare_q) begin
        cause_ti  <= 1'b1;
      end

      if (exc_valid) begin
        // Nested exceptions keep the original return address and BD flag.
        if (!status_exl) begin
          epc_q    <= exc_bd ? (exc_epc - 32'd4) : exc_epc;
          cause_bd <= exc_bd;
        end
        status_exl <= 1'b1;
        cause_exc  <= exc_code;
      end else if (eret) begin
        status_exl <= 1'b0;
      end else if (wr_status) begin
        status_im  <= write_data[15:8];
        status_exl <= write_data[1];
        status_ie  <= write_data[0];
      end

      if (!exc_valid && wr_cause) cause_sw <= write_data[9:8];
      if (!exc_valid && wr_epc)   epc_q    <= write_data;

      if (exc_valid && exc_badvaddr_en) badvaddr_q <= exc_badvaddr;
      else if (wr_badvaddr)             badvaddr_q <= write_data;
    end
  end

endmodule
